// File: rtl/cpu_multicycle_param.sv
// Parametrised multicycle bus-based processor: NREGS registers, A/G accumulator ALU,
// Z flag, T0..T3 control FSM. Optional retired-instruction counter under CPU_RETIRE_CNT_EN.
`timescale 1ns/1ps
module cpu_multicycle_param #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] buswires,
  output logic              done,
  output logic              busy
`ifdef CPU_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  localparam int RA_W = $clog2(NREGS);
  localparam int IR_W = 3 + 2 * RA_W;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MVNZ = 3'b111;

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;
  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0, SEL_DIN = 3'd1, SEL_RX = 3'd2, SEL_RY = 3'd3, SEL_G = 3'd4
  } bus_sel_t;

  function automatic logic [DATA_W-1:0] alu_fn(input logic [2:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  alu_fn = a + b;
      OP_SUB:  alu_fn = a + ~b + DATA_W'(1);
      OP_AND:  alu_fn = a & b;
      OP_OR:   alu_fn = a | b;
      OP_XOR:  alu_fn = a ^ b;
      default: alu_fn = {DATA_W{1'b0}};
    endcase
  endfunction

  // mv, mvi and mvnz finish in T1; everything else goes through the ALU
  function automatic logic is_move(input logic [2:0] op);
    is_move = (op == OP_MV) || (op == OP_MVI) || (op == OP_MVNZ);
  endfunction

  state_t            state_r, state_s;
  bus_sel_t          bus_sel_s;
  logic [IR_W-1:0]   ir_r;
  logic [DATA_W-1:0] regs_r [NREGS];
  logic [DATA_W-1:0] a_r, g_r, alu_s;
  logic              z_r;
  logic              done_r, busy_r, done_s, busy_s;
  logic              ir_we_s, a_we_s, g_we_s, reg_we_s;
  logic [2:0]        op_s, next_op_s;
  logic [RA_W-1:0]   rx_s, ry_s;

  assign op_s = ir_r[IR_W-1 -: 3];
  assign rx_s = ir_r[2*RA_W-1 -: RA_W];
  assign ry_s = ir_r[RA_W-1:0];

  // Control FSM: next state, bus source and write enables
  always_comb begin
    state_s   = state_r;
    bus_sel_s = SEL_ZERO;
    ir_we_s   = 1'b0;
    a_we_s    = 1'b0;
    g_we_s    = 1'b0;
    reg_we_s  = 1'b0;
    case (state_r)
      T0: begin
        if (run) begin
          ir_we_s = 1'b1;
          state_s = T1;
        end else begin
          state_s = T0;
        end
      end
      T1: begin
        case (op_s)
          OP_MV: begin
            bus_sel_s = SEL_RY;
            reg_we_s  = 1'b1;
            state_s   = T0;
          end
          OP_MVI: begin
            bus_sel_s = SEL_DIN;
            reg_we_s  = 1'b1;
            state_s   = T0;
          end
          OP_MVNZ: begin
            bus_sel_s = SEL_RY;
            reg_we_s  = ~z_r;
            state_s   = T0;
          end
          default: begin
            bus_sel_s = SEL_RX;
            a_we_s    = 1'b1;
            state_s   = T2;
          end
        endcase
      end
      T2: begin
        bus_sel_s = SEL_RY;
        g_we_s    = 1'b1;
        state_s   = T3;
      end
      T3: begin
        bus_sel_s = SEL_G;
        reg_we_s  = 1'b1;
        state_s   = T0;
      end
      default: begin
        state_s = T0;
      end
    endcase
  end

  // Single-source bus mux; din only reaches the bus in mvi T1
  always_comb begin
    buswires = {DATA_W{1'b0}};
    case (bus_sel_s)
      SEL_DIN:  buswires = din;
      SEL_RX:   buswires = regs_r[rx_s];
      SEL_RY:   buswires = regs_r[ry_s];
      SEL_G:    buswires = g_r;
      default:  buswires = {DATA_W{1'b0}};
    endcase
  end

  assign alu_s = alu_fn(op_s, a_r, buswires);

  // Look-ahead decode so done/busy can be registered yet align with the state they describe
  always_comb begin
    next_op_s = op_s;
    done_s    = 1'b0;
    busy_s    = (state_s != T0);
    if (ir_we_s) begin
      next_op_s = din[IR_W-1 -: 3];
    end else begin
      next_op_s = op_s;
    end
    if (state_s == T3) begin
      done_s = 1'b1;
    end else if (state_s == T1) begin
      done_s = is_move(next_op_s);
    end else begin
      done_s = 1'b0;
    end
  end

  // State, instruction, accumulator, result, flag and status registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= T0;
      ir_r    <= {IR_W{1'b0}};
      a_r     <= {DATA_W{1'b0}};
      g_r     <= {DATA_W{1'b0}};
      z_r     <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
      if (ir_we_s) begin
        ir_r <= din[IR_W-1:0];
      end
      if (a_we_s) begin
        a_r <= buswires;
      end
      if (g_we_s) begin
        g_r <= alu_s;
        z_r <= (alu_s == {DATA_W{1'b0}});
      end
    end
  end

  // General register file, written from the bus
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (reg_we_s) begin
      regs_r[rx_s] <= buswires;
    end
  end

  assign done = done_r;
  assign busy = busy_r;

`ifdef CPU_RETIRE_CNT_EN
  logic [31:0] retire_cnt_r;

  // Retired-instruction counter, one count per done cycle, wraps naturally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      retire_cnt_r <= 32'd0;
    end else if (done_r) begin
      retire_cnt_r <= retire_cnt_r + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_r;
`endif

endmodule

// File: doc/cpu_multicycle_param.md
Name: cpu_multicycle_param

Overview:
- Parametrised next-generation multicycle bus-based processor.
- Contains NREGS general registers, an A/G accumulator ALU, an instruction register, a state counter and a control FSM, all sharing one internal bus.
- Executes a single instruction per `run` request and signals completion with `done`.
- Adds logic ops, a conditional move, a zero flag and full async reset over the 16-bit, 8-register predecessor.

Parameters:
- DATA_W, 16, datapath, register and bus width in bits (≥ 9 and ≥ IR_W).
- NREGS, 8, number of general registers; power of two, 2..16.
- RA_W, $clog2(NREGS), register-address field width. Derived; not to be overridden.
- IR_W, 3+2*RA_W, instruction width, taken from `din[IR_W-1:0]`. Derived.

Ports:
- clk  in  1  system clock, rising-edge.
- resetn  in  1  asynchronous active-low reset.
- run  in  1  start request, sampled only in state T0.
- din  in  DATA_W  instruction word in T0 (low IR_W bits); immediate data in T1 for `mvi`.
- buswires  out  DATA_W  internal bus value, combinational.
- done  out  1  high during the final cycle of every instruction.
- busy  out  1  high in T1..T3 (registered state decode).
- retire_cnt  out  32  retired-instruction count. Present only with CPU_RETIRE_CNT_EN.

Behaviour:
- Reset (resetn=0, async):
  - R0..R(NREGS-1), A, G, IR, Z flag and state all clear to 0; state = T0.
  - Outputs: done=0, busy=0, buswires=0.
  - Reset mid-instruction aborts it; no register write completes.
- Instruction format: IR = {op[2:0], rx[RA_W-1:0], ry[RA_W-1:0]}, MSB first.
- Opcodes:
  - 000 mv: Rx←Ry
  - 001 mvi: Rx←din
  - 010 add
  - 011 sub
  - 100 and
  - 101 or
  - 110 xor
  - 111 mvnz: Rx←Ry only if Z=0
- FSM states T0..T3, 2-bit counter, one clock per state:
  - T0: bus=0. If run=1, IR←din[IR_W-1:0], go T1; otherwise stay T0.
  - T1, mv: bus=Ry, Rx←bus, done=1, go T0.
  - T1, mvi: bus=din, Rx←bus, done=1, go T0.
  - T1, mvnz: bus=Ry, write Rx only if Z=0, done=1 regardless, go T0.
  - T1, ALU op: bus=Rx, A←bus, go T2.
  - T2: bus=Ry; G←A op bus; Z←(result==0); go T3.
  - T3: bus=G, Rx←bus, done=1, go T0.
- Latency: mv/mvi/mvnz take 2 cycles including fetch; ALU ops take 4.
- Arithmetic: add/sub are modulo 2^DATA_W with no carry out; sub = A + ~B + 1.
- Z flag: updated only in T2 of ALU ops; holds its value otherwise, including across mv/mvi/mvnz.
- Handshake:
  - run while busy=1 is ignored, not queued.
  - run held high across done causes back-to-back fetch: the T0 immediately following done fetches a new instruction.
- Same register as Rx and Ry: legal. Reads see the pre-edge value; e.g. add R2,R2 doubles R2.
- Bus mux priority: exactly one source per state, no contention. Unused bus cycles drive 0.
- X on din outside the T0 fetch and the mvi T1 cycle must not propagate to state.

Optional Feature:
- Macro: CPU_RETIRE_CNT_EN.
- Defined:
  - 32-bit counter `retire_cnt` increments on every cycle with done=1, and wraps at 2^32 to 0.
  - Cleared by resetn.
  - mvnz with Z=1 still counts.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset then mvi R0,#0x0005 (run pulse, din=instr, then din=0x0005) → done in cycle 2, R0=0x0005, busy low after.
2. R0=5, R1=3: add R0,R1 → done on 4th cycle, bus=0x0008 in T3, R0=0x0008, Z=0. Then sub R1,R1 → R1=0x0000, Z=1.
3. Z=1: mvnz R2,R0 → R2 unchanged, done=1. Make Z=0 via add, then mvnz R2,R0 → R2=R0.
4. R3=0xFFFF, R4=0x0001: add R3,R4 → R3=0x0000 (wrap), Z=1. xor R4,R4 → 0x0000. and/or with 0xF0F0/0x0FF0 → 0x00F0 / 0xFFF0.
5. run held high over three consecutive instructions → no idle gap beyond T0 fetch. resetn low in T2 → all registers 0, state T0, done=0 immediately (async).
6. Params DATA_W=32, NREGS=16 (IR_W=11): mvi R15,#0x8000_0001; add R15,R15 → R15=0x0000_0002. With CPU_RETIRE_CNT_EN, retire_cnt=2.
